// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs feeding a 4-lane common data bus.
// Round-robin grant of up to 4 sources per cycle; bus outputs fully registered.
module cdb_arbiter #(
  parameter int NUM_SRC    = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [4*NUM_SRC-1:0]    src_rob_index_flat,
  input  logic [16*NUM_SRC-1:0]   src_result_flat,
  output logic [3:0]              cdb_valid_flat,
  output logic [15:0]             cdb_rob_index_flat,
  output logic [63:0]             cdb_result_flat,
  output logic [2:0]              cdb_lane_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(NUM_SRC);

  logic               r_en;
  logic [SW-1:0]      r_rr;
  logic [3:0]         r_cdb_vld;
  logic [15:0]        r_cdb_idx;
  logic [63:0]        r_cdb_res;
  logic [2:0]         r_cdb_cnt;

  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_nempty;
  logic [3:0]         w_hidx [NUM_SRC];
  logic [15:0]        w_hres [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [3:0]    r_idx [FIFO_DEPTH];
    logic [15:0]   r_res [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    // ready looks only at registered count, never at src_valid
    assign w_nempty[g]  = (r_cnt != '0);
    assign src_ready[g] = r_en && (r_cnt < CW'(FIFO_DEPTH));
    assign w_push[g]    = src_valid[g] & src_ready[g];
    assign w_hidx[g]    = r_idx[r_rp];
    assign w_hres[g]    = r_res[r_rp];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[g])
          r_wp <= (r_wp == AW'(FIFO_DEPTH - 1)) ? '0 : r_wp + AW'(1);
        if (w_pop[g])
          r_rp <= (r_rp == AW'(FIFO_DEPTH - 1)) ? '0 : r_rp + AW'(1);
        case ({w_push[g], w_pop[g]})
          2'b10:   r_cnt <= r_cnt + CW'(1);
          2'b01:   r_cnt <= r_cnt - CW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push[g]) begin
        r_idx[r_wp] <= src_rob_index_flat[4*g +: 4];
        r_res[r_wp] <= src_result_flat[16*g +: 16];
      end
    end
  end

  logic [2:0]    w_ng;
  logic [1:0]    w_slot;
  logic [SW:0]   w_sum;
  logic [SW-1:0] w_s;
  logic [SW-1:0] w_last;
  logic [3:0]    w_vld;
  logic [15:0]   w_idx;
  logic [63:0]   w_res;

  // lane j sits at bit/field 3-j, so slot counts down from 3
  always_comb begin
    w_ng   = '0;
    w_slot = '0;
    w_sum  = '0;
    w_s    = '0;
    w_last = r_rr;
    w_pop  = '0;
    w_vld  = '0;
    w_idx  = '0;
    w_res  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, r_rr} + (SW+1)'(k);
      if (w_sum >= (SW+1)'(NUM_SRC))
        w_sum = w_sum - (SW+1)'(NUM_SRC);
      w_s = w_sum[SW-1:0];
      if (w_nempty[w_s] && (w_ng < 3'd4)) begin
        w_slot                        = 2'd3 - w_ng[1:0];
        w_vld[w_slot]                 = 1'b1;
        w_idx[{w_slot, 2'b00} +: 4]   = w_hidx[w_s];
        w_res[{w_slot, 4'b0000} +: 16] = w_hres[w_s];
        w_pop[w_s]                    = 1'b1;
        w_last                        = w_s;
        w_ng                          = w_ng + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en      <= 1'b0;
      r_rr      <= '0;
      r_cdb_vld <= '0;
      r_cdb_idx <= '0;
      r_cdb_res <= '0;
      r_cdb_cnt <= '0;
    end else begin
      r_en      <= 1'b1;
      r_cdb_vld <= w_vld;
      r_cdb_idx <= w_idx;
      r_cdb_res <= w_res;
      r_cdb_cnt <= w_ng;
      if (w_ng != '0)
        r_rr <= (w_last == SW'(NUM_SRC - 1)) ? '0 : w_last + SW'(1);
    end
  end

  assign cdb_valid_flat     = r_cdb_vld;
  assign cdb_rob_index_flat = r_cdb_idx;
  assign cdb_result_flat    = r_cdb_res;
  assign cdb_lane_count     = r_cdb_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of the 6-source, 4-lane CDB arbiter.
// Each scenario task drives its own stimulus and compares inline.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  src_valid = '0;
  logic [5:0]  src_ready;
  logic [23:0] src_idx = '0;
  logic [95:0] src_res = '0;
  logic [3:0]  cdb_valid;
  logic [15:0] cdb_idx;
  logic [63:0] cdb_res;
  logic [2:0]  cdb_cnt;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.NUM_SRC(6), .FIFO_DEPTH(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .src_valid          (src_valid),
    .src_ready          (src_ready),
    .src_rob_index_flat (src_idx),
    .src_result_flat    (src_res),
    .cdb_valid_flat     (cdb_valid),
    .cdb_rob_index_flat (cdb_idx),
    .cdb_result_flat    (cdb_res),
    .cdb_lane_count     (cdb_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [3:0] i,
                         input logic [15:0] r);
    src_idx[4*s +: 4]   = i;
    src_res[16*s +: 16] = r;
  endtask

  task automatic apply_reset;
    rst_n     = 1'b0;
    src_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n     = 1'b1;
    src_valid = 6'h3F;
    src_idx   = 24'h123456;
    src_res   = {6{16'hA5A5}};
    #1 rst_n = 1'b0;
    #1;
    checks++; if (cdb_valid !== 4'h0) begin failures++; $display("FAIL rst_async_valid got=%h want=0", cdb_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (src_ready !== 6'h00) begin failures++; $display("FAIL rst_ready c%0d got=%h want=00", c, src_ready); end
      checks++; if (cdb_valid !== 4'h0) begin failures++; $display("FAIL rst_valid c%0d got=%h want=0", c, cdb_valid); end
      checks++; if (cdb_cnt !== 3'd0 || cdb_idx !== 16'h0 || cdb_res !== 64'h0) begin failures++; $display("FAIL rst_bus c%0d cnt=%0d idx=%h res=%h want=0", c, cdb_cnt, cdb_idx, cdb_res); end
    end
    rst_n     = 1'b1;
    src_valid = '0;
    checks++; if (src_ready !== 6'h00) begin failures++; $display("FAIL rel_ready_same got=%h want=00", src_ready); end
    tick();
    checks++; if (src_ready !== 6'h3F) begin failures++; $display("FAIL rel_ready_next got=%h want=3f", src_ready); end
    checks++; if (cdb_valid !== 4'h0) begin failures++; $display("FAIL rel_valid got=%h want=0", cdb_valid); end
  endtask

  task automatic test_single;
    set_src(2, 4'h5, 16'hBEEF);
    src_valid = 6'b000100;
    tick();
    src_valid = '0;
    checks++; if (cdb_valid !== 4'h0) begin failures++; $display("FAIL single_e1 got=%h want=0", cdb_valid); end
    tick();
    checks++; if (cdb_valid !== 4'b1000) begin failures++; $display("FAIL single_valid got=%b want=1000", cdb_valid); end
    checks++; if (cdb_idx !== 16'h5000) begin failures++; $display("FAIL single_idx got=%h want=5000", cdb_idx); end
    checks++; if (cdb_res !== 64'hBEEF_0000_0000_0000) begin failures++; $display("FAIL single_res got=%h want=beef000000000000", cdb_res); end
    checks++; if (cdb_cnt !== 3'd1) begin failures++; $display("FAIL single_cnt got=%0d want=1", cdb_cnt); end
    tick();
    checks++; if (cdb_valid !== 4'h0 || cdb_idx !== 16'h0 || cdb_res !== 64'h0 || cdb_cnt !== 3'd0) begin failures++; $display("FAIL single_after v=%h i=%h r=%h c=%0d want=0", cdb_valid, cdb_idx, cdb_res, cdb_cnt); end
  endtask

  task automatic test_six;
    apply_reset();
    for (int s = 0; s < 6; s++) set_src(s, 4'(s), 16'h1000 + 16'(s));
    src_valid = 6'h3F;
    tick();
    src_valid = '0;
    tick();
    checks++; if (cdb_valid !== 4'b1111 || cdb_cnt !== 3'd4) begin failures++; $display("FAIL six_a_valid v=%b c=%0d want=1111/4", cdb_valid, cdb_cnt); end
    checks++; if (cdb_idx !== 16'h0123) begin failures++; $display("FAIL six_a_idx got=%h want=0123", cdb_idx); end
    checks++; if (cdb_res !== 64'h1000_1001_1002_1003) begin failures++; $display("FAIL six_a_res got=%h want=1000100110021003", cdb_res); end
    tick();
    checks++; if (cdb_valid !== 4'b1100 || cdb_cnt !== 3'd2) begin failures++; $display("FAIL six_b_valid v=%b c=%0d want=1100/2", cdb_valid, cdb_cnt); end
    checks++; if (cdb_idx !== 16'h4500) begin failures++; $display("FAIL six_b_idx got=%h want=4500", cdb_idx); end
    checks++; if (cdb_res !== 64'h1004_1005_0000_0000) begin failures++; $display("FAIL six_b_res got=%h want=1004100500000000", cdb_res); end
    set_src(0, 4'hA, 16'hAAAA);
    set_src(5, 4'hB, 16'hBBBB);
    src_valid = 6'b100001;
    tick();
    src_valid = '0;
    tick();
    checks++; if (cdb_valid !== 4'b1100 || cdb_idx !== 16'hAB00) begin failures++; $display("FAIL six_rr0 v=%b i=%h want=1100/ab00", cdb_valid, cdb_idx); end
    tick();
    checks++; if (cdb_valid !== 4'h0) begin failures++; $display("FAIL six_idle got=%h want=0", cdb_valid); end
  endtask

  task automatic test_backpressure;
    logic [5:0]  acc;
    int          seq [6];
    logic [5:0]  rdy_exp [6];
    logic [63:0] res_exp [6];
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      set_src(0, 4'(i), 16'(i));
      src_valid = 6'b000001;
      checks++; if (src_ready[0] !== 1'b1) begin failures++; $display("FAIL bp_solo_ready i%0d got=%b want=1", i, src_ready[0]); end
      tick();
      if (i >= 2) begin
        checks++; if (cdb_valid !== 4'b1000 || cdb_idx[15:12] !== 4'(i - 1)) begin failures++; $display("FAIL bp_solo_out i%0d v=%b idx=%h want=1000/%h", i, cdb_valid, cdb_idx[15:12], 4'(i - 1)); end
      end
    end
    src_valid = '0;
    tick();
    checks++; if (cdb_idx[15:12] !== 4'h6) begin failures++; $display("FAIL bp_solo_last got=%h want=6", cdb_idx[15:12]); end

    rdy_exp = '{6'h00, 6'h3F, 6'h0F, 6'h33, 6'h3C, 6'h0F};
    res_exp = '{64'h0, 64'h0,
                64'h0001_1001_2001_3001,
                64'h4001_5001_0002_1002,
                64'h2002_3002_4002_5002,
                64'h0003_1003_2003_3003};
    apply_reset();
    for (int s = 0; s < 6; s++) seq[s] = 1;
    for (int e = 1; e <= 5; e++) begin
      for (int s = 0; s < 6; s++)
        set_src(s, 4'(seq[s]), {4'(s), 8'h00, 4'(seq[s])});
      src_valid = 6'h3F;
      acc = src_valid & src_ready;
      tick();
      for (int s = 0; s < 6; s++) if (acc[s]) seq[s]++;
      checks++; if (src_ready !== rdy_exp[e]) begin failures++; $display("FAIL bp_ready e%0d got=%h want=%h", e, src_ready, rdy_exp[e]); end
      checks++; if (cdb_res !== res_exp[e]) begin failures++; $display("FAIL bp_res e%0d got=%h want=%h", e, cdb_res, res_exp[e]); end
    end
    src_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_fairness;
    logic [5:0]  acc;
    logic [15:0] r;
    int          seq [6];
    int          nxt [6];
    int          gr [16][6];
    int          s;
    int          sum;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      seq[i] = 1;
      nxt[i] = 1;
    end
    for (int t = 0; t < 16; t++)
      for (int i = 0; i < 6; i++) gr[t][i] = 0;
    for (int t = 1; t <= 15; t++) begin
      for (int i = 0; i < 6; i++)
        set_src(i, 4'(seq[i]), {4'(i), 8'h00, 4'(seq[i])});
      src_valid = 6'h3F;
      acc = src_valid & src_ready;
      tick();
      for (int i = 0; i < 6; i++) if (acc[i]) seq[i]++;
      if (t >= 2) begin
        checks++; if (cdb_cnt !== 3'd4 || cdb_valid !== 4'hF) begin failures++; $display("FAIL fair_full t%0d cnt=%0d v=%h want=4/f", t, cdb_cnt, cdb_valid); end
        for (int j = 0; j < 4; j++) begin
          r = cdb_res[16*(3-j) +: 16];
          s = int'(r[15:12]);
          checks++;
          if (s > 5) begin
            failures++; $display("FAIL fair_src t%0d lane%0d got=%0d want<6", t, j, s);
          end else begin
            if (r[3:0] !== 4'(nxt[s])) begin failures++; $display("FAIL fair_order t%0d src%0d got=%h want=%h", t, s, r[3:0], 4'(nxt[s])); end
            nxt[s]++;
            gr[t][s]++;
          end
        end
      end
    end
    for (int t = 2; t <= 13; t++)
      for (int i = 0; i < 6; i++) begin
        sum = gr[t][i] + gr[t+1][i] + gr[t+2][i];
        checks++; if (sum != 2) begin failures++; $display("FAIL fair_window t%0d src%0d got=%0d want=2", t, i, sum); end
      end
    src_valid = '0;
    repeat (6) tick();
  endtask

  task automatic test_async_reset;
    apply_reset();
    for (int s = 0; s < 6; s++) set_src(s, 4'(s + 1), 16'hC000 + 16'(s));
    src_valid = 6'h3F;
    tick();
    for (int s = 0; s < 3; s++) set_src(s, 4'(s + 8), 16'hD000 + 16'(s));
    src_valid = 6'b000111;
    tick();
    src_valid = '0;
    checks++; if (cdb_valid !== 4'hF) begin failures++; $display("FAIL ar_pre got=%h want=f", cdb_valid); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (cdb_valid !== 4'h0 || cdb_cnt !== 3'd0) begin failures++; $display("FAIL ar_immediate v=%h c=%0d want=0/0", cdb_valid, cdb_cnt); end
    checks++; if (src_ready !== 6'h00) begin failures++; $display("FAIL ar_ready got=%h want=00", src_ready); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (cdb_valid !== 4'h0 || cdb_res !== 64'h0) begin failures++; $display("FAIL ar_drain c%0d v=%h r=%h want=0", c, cdb_valid, cdb_res); end
    end
    checks++; if (src_ready !== 6'h3F) begin failures++; $display("FAIL ar_ready_after got=%h want=3f", src_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_six();
    test_backpressure();
    test_fairness();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
